// File: rtl/mill_modif_pkg.sv
// Shared definitions for the ISO14443-A Modified Miller encoder.
//  - state_t : encoder FSM states (also exposed on the debug port)
//  - sym_t   : line symbols X (carrier|pause), Y (carrier|carrier), Z (pause|carrier)
//  - code_bit: Modified Miller bit-to-symbol rule
package mill_modif_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SOF    = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_EOF0   = 3'd4,
    ST_EOF1   = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    SYM_X = 2'd0,
    SYM_Y = 2'd1,
    SYM_Z = 2'd2
  } sym_t;

  // 1 -> X; 0 -> Y after a coded 1, Z after a coded 0 or SOF.
  function automatic sym_t code_bit(input logic b, input logic prev);
    if (b) begin
      return SYM_X;
    end else if (prev) begin
      return SYM_Y;
    end else begin
      return SYM_Z;
    end
  endfunction

endpackage

// File: rtl/mill_modif_sym.sv
// Symbol shaper: turns a symbol code plus the phase inside the ETU into the
// line level, and registers it so the line is glitch-free.
// Ports:
//  clk, rst  : clock, asynchronous active-high reset (line idles at 1)
//  i_sym     : symbol to shape (X/Y/Z)
//  i_etu     : phase 0..2*HALF-1 inside the ETU
//  i_idle    : 1 -> drive carrier regardless of symbol
//  o_line    : registered line level, 1 = carrier, 0 = pause
module mill_modif_sym
  import mill_modif_pkg::*;
#(
  parameter int HALF  = 4,
  parameter int PAUSE = 4,
  parameter int CW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  sym_t          i_sym,
  input  logic [CW-1:0] i_etu,
  input  logic          i_idle,
  output logic          o_line
);

  logic          w_first_half;
  logic [CW-1:0] w_phase;
  logic          w_pause;
  logic          w_level;

  // Pause occupies the first PAUSE clocks of the paused half.
  always_comb begin
    w_first_half = (i_etu < CW'(HALF));
    w_phase      = w_first_half ? i_etu : (i_etu - CW'(HALF));
    w_pause      = (w_phase < CW'(PAUSE));
    case (i_sym)
      SYM_X:   w_level = !(!w_first_half && w_pause);
      SYM_Z:   w_level = !(w_first_half && w_pause);
      default: w_level = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_line <= 1'b1;
    end else begin
      o_line <= i_idle ? 1'b1 : w_level;
    end
  end

endmodule

// File: rtl/mill_modif_mod.sv
// ISO14443-A PCD->PICC Modified Miller encoder (106 kb/s).
// Accepts frame bytes on a valid/ready stream, sends SOF, data LSB first with
// optional odd parity per full byte, then EOF, on a pause-modulated line.
// Ports:
//  clk, rst      : clock, asynchronous active-high reset
//  in_enable     : 0 aborts synchronously to IDLE (same values as reset)
//  in_valid      : in_data/in_last/in_bits valid
//  in_data       : frame byte, sent LSB first
//  in_last       : byte is the last of the frame
//  in_bits       : valid LSBs of a last byte, 0 means 8
//  out_ready     : byte accepted when in_valid & out_ready (& in_enable)
//  out_data      : line, 1 = carrier, 0 = pause
//  out_busy      : frame in progress, SOF start through end of EOF
//  out_err       : 1-clock underrun pulse at EOF0 entry
//  out_dbg_state : current FSM state
//
// Handshake: a byte transfers on a rising edge where in_valid and out_ready
// are both 1 and in_enable is 1. out_ready depends on registered state only.
// It is 1 in IDLE and during the final ETU of a non-last byte until a byte is
// taken; that byte starts at the next ETU boundary with no gap.
module mill_modif_mod
  import mill_modif_pkg::*;
#(
  parameter int HALF      = 4,
  parameter int PAUSE     = 4,
  parameter int PARITY_EN = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_enable,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       in_last,
  input  logic [2:0] in_bits,
  output logic       out_ready,
  output logic       out_data,
  output logic       out_busy,
  output logic       out_err,
  output state_t     out_dbg_state
);

  localparam int ETU = 2 * HALF;
  localparam int CW = (ETU > 1) ? $clog2(ETU) : 1;
  localparam logic [CW-1:0] ETU_LAST = CW'(ETU - 1);
  localparam bit PAR_ON = (PARITY_EN != 0);

  // Current byte and coding context
  state_t        r_state;
  logic [CW-1:0] r_etu;
  logic [3:0]    r_bit;
  logic [7:0]    r_shift;
  logic [3:0]    r_nbits;
  logic          r_last;
  logic          r_par;
  logic          r_prev;
  sym_t          r_sym;
  logic          r_err;
  // Byte taken early in the handoff window, waiting for the ETU boundary
  logic          r_nxt;
  logic [7:0]    r_nxt_data;
  logic [3:0]    r_nxt_nbits;
  logic          r_nxt_last;
  logic          r_nxt_par;

  state_t        w_state;
  logic [CW-1:0] w_etu;
  logic [3:0]    w_bit;
  logic [7:0]    w_shift;
  logic [3:0]    w_nbits;
  logic          w_last;
  logic          w_par;
  logic          w_prev;
  sym_t          w_sym;
  logic          w_err;
  logic          w_nxt;
  logic [7:0]    w_nxt_data;
  logic [3:0]    w_nxt_nbits;
  logic          w_nxt_last;
  logic          w_nxt_par;
  logic          w_handoff;

  logic          w_etu_end;
  logic          w_full;
  logic          w_final_bit;
  logic          w_final_etu;
  logic          w_window;
  logic          w_accept;
  logic [3:0]    w_in_nbits;
  logic          w_in_par;
  logic [7:0]    w_src_data;
  logic [3:0]    w_src_nbits;
  logic          w_src_last;
  logic          w_src_par;
  logic          w_line;

  assign w_etu_end   = (r_etu == ETU_LAST);
  assign w_full      = (r_nbits == 4'd8);
  assign w_final_bit = (r_bit == (r_nbits - 4'd1));
  assign w_in_nbits  = (in_last && (in_bits != 3'd0)) ? {1'b0, in_bits} : 4'd8;
  assign w_in_par    = ~^in_data;
  assign w_accept    = in_enable && in_valid && out_ready;

  // Next byte comes from the early-accept buffer, else straight from the input.
  assign w_src_data  = r_nxt ? r_nxt_data  : in_data;
  assign w_src_nbits = r_nxt ? r_nxt_nbits : w_in_nbits;
  assign w_src_last  = r_nxt ? r_nxt_last  : in_last;
  assign w_src_par   = r_nxt ? r_nxt_par   : w_in_par;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_etu       <= '0;
      r_bit       <= 4'd0;
      r_shift     <= 8'd0;
      r_nbits     <= 4'd8;
      r_last      <= 1'b0;
      r_par       <= 1'b0;
      r_prev      <= 1'b0;
      r_sym       <= SYM_Y;
      r_err       <= 1'b0;
      r_nxt       <= 1'b0;
      r_nxt_data  <= 8'd0;
      r_nxt_nbits <= 4'd8;
      r_nxt_last  <= 1'b0;
      r_nxt_par   <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_etu       <= w_etu;
      r_bit       <= w_bit;
      r_shift     <= w_shift;
      r_nbits     <= w_nbits;
      r_last      <= w_last;
      r_par       <= w_par;
      r_prev      <= w_prev;
      r_sym       <= w_sym;
      r_err       <= w_err;
      r_nxt       <= w_nxt;
      r_nxt_data  <= w_nxt_data;
      r_nxt_nbits <= w_nxt_nbits;
      r_nxt_last  <= w_nxt_last;
      r_nxt_par   <= w_nxt_par;
    end
  end

  // Next-state logic. Symbols are chosen at ETU boundaries; r_shift is
  // shifted as each bit is coded, so r_shift[0] is always the next bit.
  always_comb begin
    w_state     = r_state;
    w_etu       = w_etu_end ? '0 : (r_etu + 1'b1);
    w_bit       = r_bit;
    w_shift     = r_shift;
    w_nbits     = r_nbits;
    w_last      = r_last;
    w_par       = r_par;
    w_prev      = r_prev;
    w_sym       = r_sym;
    w_err       = 1'b0;
    w_nxt       = r_nxt;
    w_nxt_data  = r_nxt_data;
    w_nxt_nbits = r_nxt_nbits;
    w_nxt_last  = r_nxt_last;
    w_nxt_par   = r_nxt_par;
    w_handoff   = 1'b0;

    if (!in_enable) begin
      w_state = ST_IDLE;
      w_etu   = '0;
      w_bit   = 4'd0;
      w_prev  = 1'b0;
      w_nxt   = 1'b0;
    end else begin
      if (w_accept && (r_state != ST_IDLE)) begin
        w_nxt       = 1'b1;
        w_nxt_data  = in_data;
        w_nxt_nbits = w_in_nbits;
        w_nxt_last  = in_last;
        w_nxt_par   = w_in_par;
      end

      case (r_state)
        ST_IDLE: begin
          w_etu = '0;
          if (w_accept) begin
            w_state = ST_SOF;
            w_sym   = SYM_Z;
            w_prev  = 1'b0;
            w_shift = in_data;
            w_nbits = w_in_nbits;
            w_last  = in_last;
            w_par   = w_in_par;
          end
        end
        ST_SOF: begin
          if (w_etu_end) begin
            w_state = ST_DATA;
            w_bit   = 4'd0;
            w_sym   = code_bit(r_shift[0], r_prev);
            w_prev  = r_shift[0];
            w_shift = r_shift >> 1;
          end
        end
        ST_DATA: begin
          if (w_etu_end) begin
            if (!w_final_bit) begin
              w_bit   = r_bit + 4'd1;
              w_sym   = code_bit(r_shift[0], r_prev);
              w_prev  = r_shift[0];
              w_shift = r_shift >> 1;
            end else if (PAR_ON && w_full) begin
              w_state = ST_PARITY;
              w_sym   = code_bit(r_par, r_prev);
              w_prev  = r_par;
            end else begin
              w_handoff = 1'b1;
            end
          end
        end
        ST_PARITY: begin
          if (w_etu_end) begin
            w_handoff = 1'b1;
          end
        end
        ST_EOF0: begin
          if (w_etu_end) begin
            w_state = ST_EOF1;
            w_sym   = SYM_Y;
          end
        end
        ST_EOF1: begin
          if (w_etu_end) begin
            w_state = ST_IDLE;
            w_prev  = 1'b0;
          end
        end
        default: begin
          w_state = ST_IDLE;
          w_etu   = '0;
        end
      endcase

      // End of a byte's final ETU: continue with the next byte or close the frame.
      if (w_handoff) begin
        if (r_nxt || w_accept) begin
          w_state = ST_DATA;
          w_bit   = 4'd0;
          w_shift = w_src_data >> 1;
          w_nbits = w_src_nbits;
          w_last  = w_src_last;
          w_par   = w_src_par;
          w_sym   = code_bit(w_src_data[0], r_prev);
          w_prev  = w_src_data[0];
          w_nxt   = 1'b0;
        end else begin
          w_state = ST_EOF0;
          w_sym   = code_bit(1'b0, r_prev);
          w_prev  = 1'b0;
          w_err   = !r_last;
        end
      end
    end
  end

  // Output logic
  always_comb begin
    w_final_etu = (r_state == ST_PARITY) ||
                  ((r_state == ST_DATA) && w_final_bit && !(PAR_ON && w_full));
    w_window    = w_final_etu && !r_last && !r_nxt;
    out_ready   = (r_state == ST_IDLE) || w_window;
    out_busy    = (r_state != ST_IDLE);
  end

  assign out_err       = r_err;
  assign out_data      = w_line;
  assign out_dbg_state = r_state;

  // Fed with next-state values so the registered line lines up with r_state/r_etu.
  mill_modif_sym #(
    .HALF  (HALF),
    .PAUSE (PAUSE),
    .CW    (CW)
  ) u_sym (
    .clk    (clk),
    .rst    (rst),
    .i_sym  (w_sym),
    .i_etu  (w_etu),
    .i_idle (w_state == ST_IDLE),
    .o_line (w_line)
  );

endmodule

// File: tb/tb_mill_modif_mod.sv
module tb_mill_modif_mod;
  import mill_modif_pkg::*;

  localparam int HALF   = 4;
  localparam int PAUSE  = 4;
  localparam int PAUSE2 = 2;
  localparam int ETU    = 2 * HALF;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       in_enable, in_valid, in_last;
  logic [7:0] in_data;
  logic [2:0] in_bits;
  logic       out_ready, out_data, out_busy, out_err;
  state_t     out_dbg_state;
  logic       out_ready_2, out_data_2, out_busy_2, out_err_2;
  state_t     out_dbg_state_2;

  mill_modif_mod #(.HALF(HALF), .PAUSE(PAUSE), .PARITY_EN(1)) u_dut (
    .clk(clk), .rst(rst), .in_enable(in_enable), .in_valid(in_valid),
    .in_data(in_data), .in_last(in_last), .in_bits(in_bits),
    .out_ready(out_ready), .out_data(out_data), .out_busy(out_busy),
    .out_err(out_err), .out_dbg_state(out_dbg_state)
  );

  // Same stimulus, shorter pause
  mill_modif_mod #(.HALF(HALF), .PAUSE(PAUSE2), .PARITY_EN(1)) u_dut2 (
    .clk(clk), .rst(rst), .in_enable(in_enable), .in_valid(in_valid),
    .in_data(in_data), .in_last(in_last), .in_bits(in_bits),
    .out_ready(out_ready_2), .out_data(out_data_2), .out_busy(out_busy_2),
    .out_err(out_err_2), .out_dbg_state(out_dbg_state_2)
  );

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // frame under test
  logic [7:0] fr_data[8];
  int         fr_n;
  int         fr_lb;
  bit         fr_under;

  // scoreboard: per clock {line at PAUSE2, line at PAUSE}
  logic [1:0] exp_q[$];
  int         err_pos;

  function automatic logic line_level(input byte s, input int t, input int pause);
    int paused_half;
    paused_half = (s == "X") ? 1 : ((s == "Z") ? 0 : -1);
    return ((t / HALF) == paused_half && (t % HALF) < pause) ? 1'b0 : 1'b1;
  endfunction

  // Reference: bit list -> symbol list -> clocked line levels
  task automatic build_model();
    bit  bits[$];
    byte syms[$];
    bit  prev;
    int  nb, ones;
    exp_q.delete();
    for (int i = 0; i < fr_n; i++) begin
      nb = (i == fr_n - 1 && !fr_under && fr_lb != 0) ? fr_lb : 8;
      for (int j = 0; j < nb; j++) bits.push_back(fr_data[i][j]);
      if (nb == 8) begin
        ones = 0;
        for (int j = 0; j < 8; j++) ones += int'(fr_data[i][j]);
        bits.push_back((ones % 2) == 0);
      end
    end
    syms.push_back("Z");
    prev = 1'b0;
    foreach (bits[k]) begin
      syms.push_back(bits[k] ? "X" : (prev ? "Y" : "Z"));
      prev = bits[k];
    end
    syms.push_back(prev ? "Y" : "Z");
    syms.push_back("Y");
    err_pos = fr_under ? (syms.size() - 2) * ETU : -1;
    foreach (syms[k])
      for (int t = 0; t < ETU; t++)
        exp_q.push_back({line_level(syms[k], t, PAUSE2), line_level(syms[k], t, PAUSE)});
  endtask

  // Driver + per-clock compare. late=1 presents handoff bytes only on the
  // 8th ready clock; stop_at>=0 leaves the frame after that many samples.
  task automatic run_frame(input bit late, input int stop_at);
    int idx, pos, run, total;
    bit started, run_acc, done;
    logic [1:0] e;
    idx = 0; pos = 0; run = 0; started = 0; run_acc = 0; done = 0;
    build_model();
    total = exp_q.size();
    for (int c = 0; c < total + 200 && !done; c++) begin
      @(negedge clk);
      if (started) begin
        if (pos < total) begin
          e = exp_q.pop_front();
          check($sformatf("line pos=%0d", pos), out_data, e[0]);
          check($sformatf("line_p2 pos=%0d", pos), out_data_2, e[1]);
          check("busy", out_busy, 1);
          check($sformatf("err pos=%0d", pos), out_err, (pos == err_pos));
          if (out_ready) begin
            run++;
          end else if (run > 0) begin
            check("ready_run", run, (run_acc && !late) ? 1 : 8);
            run = 0;
            run_acc = 0;
          end
        end else begin
          check("line_idle", out_data, 1);
          check("busy_end", out_busy, 0);
          check("err_end", out_err, 0);
          done = 1;
        end
        pos++;
        if (stop_at >= 0 && pos == stop_at) done = 1;
      end
      if (!done) begin
        in_valid = (idx < fr_n) && (idx == 0 || !late || run == 8);
        in_data  = fr_data[(idx < fr_n) ? idx : 0];
        in_last  = (idx == fr_n - 1) && !fr_under;
        in_bits  = fr_lb[2:0];
        if (in_valid && out_ready) begin
          idx++;
          if (!started) started = 1;
          else run_acc = 1;
        end
      end
    end
    in_valid = 1'b0;
    check("frame_done", done, 1);
  endtask

  task automatic set_frame(input logic [7:0] b0, input logic [7:0] b1, input int n,
                           input int lb, input bit under);
    fr_data[0] = b0; fr_data[1] = b1; fr_n = n; fr_lb = lb; fr_under = under;
  endtask

  initial begin
    rst = 1'b1; in_enable = 1'b1; in_valid = 1'b0;
    in_data = 8'd0; in_last = 1'b0; in_bits = 3'd0;
    #12;
    check("rst_line", out_data, 1);
    check("rst_busy", out_busy, 0);
    check("rst_ready", out_ready, 1);
    check("rst_err", out_err, 0);
    check("rst_state", out_dbg_state, ST_IDLE);
    @(negedge clk);
    rst = 1'b0;

    // REQA short frame, 7 bits
    set_frame(8'h26, 8'h00, 1, 7, 0);
    run_frame(0, -1);
    // single full byte with parity
    set_frame(8'h93, 8'h00, 1, 0, 0);
    run_frame(0, -1);
    // two bytes, late and early handoff
    set_frame(8'h93, 8'h20, 2, 0, 0);
    run_frame(1, -1);
    run_frame(0, -1);
    // underrun
    set_frame(8'h93, 8'h00, 1, 0, 1);
    run_frame(0, -1);

    // async reset mid-DATA
    set_frame(8'h93, 8'h20, 2, 0, 0);
    run_frame(0, 40);
    rst = 1'b1;
    #1;
    check("arst_line", out_data, 1);
    check("arst_busy", out_busy, 0);
    check("arst_ready", out_ready, 1);
    check("arst_err", out_err, 0);
    @(negedge clk);
    rst = 1'b0;
    set_frame(8'h26, 8'h00, 1, 7, 0);
    run_frame(0, -1);

    // synchronous abort mid-DATA, valid held while disabled
    set_frame(8'h93, 8'h20, 2, 0, 0);
    run_frame(0, 30);
    in_enable = 1'b0;
    in_valid  = 1'b1;
    check("abort_busy_before", out_busy, 1);
    @(negedge clk);
    check("abort_line", out_data, 1);
    check("abort_busy", out_busy, 0);
    check("abort_ready", out_ready, 1);
    @(negedge clk);
    check("abort_ignore_busy", out_busy, 0);
    check("abort_ignore_state", out_dbg_state, ST_IDLE);
    in_valid  = 1'b0;
    in_enable = 1'b1;
    set_frame(8'h93, 8'h00, 1, 0, 0);
    run_frame(0, -1);

    // all-zero byte (PAUSE=2 shape on second instance)
    set_frame(8'h00, 8'h00, 1, 0, 0);
    run_frame(0, -1);

    // randomized frames
    for (int r = 0; r < 10; r++) begin
      fr_n = $urandom_range(1, 4);
      for (int i = 0; i < 8; i++) fr_data[i] = 8'($urandom_range(0, 255));
      fr_lb    = $urandom_range(0, 7);
      fr_under = ($urandom_range(0, 3) == 0);
      run_frame(1'($urandom_range(0, 1)), -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
